// File: rtl/rf_codebook_pkg.sv
// Shared codebook for the RF symbol transmitter and correlator receiver.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rf_codebook_pkg;

  localparam int CODE_BITS = 32;
  localparam int SYM_BITS  = 4;
  localparam int NUM_SYMS  = 16;

  typedef logic [SYM_BITS-1:0]  symbol_t;
  typedef logic [CODE_BITS-1:0] code_t;

  // Hadamard row k: bit i is set when i and k share an even number of ones.
  function automatic code_t code_of(symbol_t k);
    code_t      w_c;
    logic [4:0] w_i;
    w_c = '0;
    for (int i = 0; i < CODE_BITS; i++) begin
      w_i    = i[4:0];
      w_c[i] = ~^(w_i & {1'b0, k});
    end
    return w_c;
  endfunction

  // Receiver correlation target: agreements minus disagreements against row k.
  // A clean copy of row k scores CODE_BITS; every other row scores 0.
  function automatic int corr_score(code_t rx, symbol_t k);
    return CODE_BITS - 2 * $countones(rx ^ code_of(k));
  endfunction

endpackage

// File: rtl/rf_symbol_transmitter_if.sv
// Symbol source to transmitter handshake plus the serial/status outputs.
// Latency: n/a (wiring only).
// Backpressure: Symbol_ready low stalls the source, which must hold Symbol.
interface rf_symbol_transmitter_if;
  import rf_codebook_pkg::*;

  symbol_t Symbol;
  logic    Symbol_valid;
  logic    Symbol_ready;
  logic    Bit_stream;
  logic    Frame_start;
  logic    Busy;

  // Symbol source side.
  modport master (
    output Symbol, Symbol_valid,
    input  Symbol_ready, Bit_stream, Frame_start, Busy
  );

  // Transmitter side.
  modport slave (
    input  Symbol, Symbol_valid,
    output Symbol_ready, Bit_stream, Frame_start, Busy
  );

endinterface

// File: rtl/rf_code_rom.sv
// Combinational symbol to 32-bit Hadamard codeword lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module rf_code_rom
  import rf_codebook_pkg::*;
(
  input  symbol_t i_sym,
  output code_t   o_code
);

  assign o_code = code_of(i_sym);

endmodule

// File: rtl/rf_symbol_transmitter.sv
// Maps accepted 4-bit symbols to 32-bit codewords, sent LSB-first in fixed slots.
// Latency: accept to first bit = (last slot index - sc at accept) + 1 cycles.
// Backpressure: one-entry hold; ready only when hold is empty or in the last slot cycle.
module rf_symbol_transmitter
  import rf_codebook_pkg::*;
#(
  // Idle cycles after the 32 bit cycles; must be >= 1, and 1 to line up
  // with the receiver's frame counter.
  parameter int GAP_CYCLES = 1
) (
  input logic                   Clock,
  input logic                   Reset,
  rf_symbol_transmitter_if.slave bus
);

  localparam int              SLOT_LEN     = CODE_BITS + GAP_CYCLES;
  localparam int              SC_W         = $clog2(SLOT_LEN);
  localparam logic [SC_W-1:0] SC_LAST      = SC_W'(SLOT_LEN - 1);
  localparam logic [SC_W-1:0] SC_FIRST_GAP = SC_W'(CODE_BITS);

  logic [SC_W-1:0] r_sc;
  code_t           r_sh;
  symbol_t         r_hold;
  logic            r_hold_valid;
  logic            r_active;

  logic            w_last;
  logic            w_ready;
  logic            w_accept;
  code_t           w_code;

  assign w_last   = (r_sc == SC_LAST);
  // The last slot cycle frees the hold register on the same edge it reloads.
  assign w_ready  = !r_hold_valid || w_last;
  assign w_accept = bus.Symbol_valid && w_ready;

  rf_code_rom u_rom (
    .i_sym  (r_hold),
    .o_code (w_code)
  );

  // Free-running slot counter, independent of traffic so slots stay aligned
  // with the receiver.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sc <= '0;
    end else if (w_last) begin
      r_sc <= '0;
    end else begin
      r_sc <= r_sc + 1'b1;
    end
  end

  // Hold register: capture on accept, empty when handed to the shifter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold       <= bus.Symbol;
      r_hold_valid <= 1'b1;
    end else if (w_last) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Shifter: load a codeword (or zeros for an idle slot) at the slot
  // boundary, shift toward bit 0 otherwise; zero fill makes the gap silent.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sh     <= '0;
      r_active <= 1'b0;
    end else if (w_last) begin
      if (r_hold_valid) begin
        r_sh     <= w_code;
        r_active <= 1'b1;
      end else begin
        r_sh     <= '0;
        r_active <= 1'b0;
      end
    end else begin
      r_sh <= {1'b0, r_sh[CODE_BITS-1:1]};
    end
  end

  assign bus.Symbol_ready = w_ready;
  assign bus.Bit_stream   = r_sh[0];
  assign bus.Frame_start  = r_active && (r_sc == '0);
  assign bus.Busy         = r_hold_valid || (r_active && (r_sc < SC_FIRST_GAP));

endmodule

// File: tb/tb_rf_symbol_transmitter.sv
// Randomized scoreboard bench for rf_symbol_transmitter against a slot-level model.
// Latency: checks frame start cycles and per-cycle outputs.
// Backpressure: the source holds each symbol until the model says it is taken.
module tb_rf_symbol_transmitter;
  import rf_codebook_pkg::*;

  localparam int SLOT = 33;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  rf_symbol_transmitter_if bus();

  rf_symbol_transmitter #(.GAP_CYCLES(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int sym;
    int start;
  } exp_t;

  exp_t exp_q[$];
  int   sched_sym[int];   // slot index -> symbol sent in that slot
  int   sched_acc[int];   // slot index -> cycle the symbol was accepted

  // Codeword straight from the popcount definition.
  function automatic logic [31:0] ref_code(int k);
    logic [31:0] c;
    for (int i = 0; i < 32; i++) c[i] = (($countones(i & k) % 2) == 0);
    return c;
  endfunction

  // A symbol is waiting if the next slot is booked by an accept already made.
  function automatic bit m_hold(int c);
    int s;
    s = c / SLOT;
    if (sched_acc.exists(s + 1)) return sched_acc[s + 1] < c;
    return 1'b0;
  endfunction

  function automatic bit m_ready(int c);
    return !m_hold(c) || ((c % SLOT) == SLOT - 1);
  endfunction

  function automatic bit m_bit(int c);
    int          s;
    int          n;
    logic [31:0] w;
    s = c / SLOT;
    n = c % SLOT;
    if (sched_sym.exists(s) && n < 32) begin
      w = ref_code(sched_sym[s]);
      return w[n];
    end
    return 1'b0;
  endfunction

  function automatic bit m_fs(int c);
    return sched_sym.exists(c / SLOT) && ((c % SLOT) == 0);
  endfunction

  function automatic bit m_busy(int c);
    return m_hold(c) || (sched_sym.exists(c / SLOT) && ((c % SLOT) < 32));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: per-cycle output checks plus frame scoreboard.
  int          col_n = -1;
  logic [31:0] col_bits;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        chk("bit_stream",   32'(bus.Bit_stream),   32'(m_bit(cyc)));
        chk("frame_start",  32'(bus.Frame_start),  32'(m_fs(cyc)));
        chk("busy",         32'(bus.Busy),         32'(m_busy(cyc)));
        chk("symbol_ready", 32'(bus.Symbol_ready), 32'(m_ready(cyc)));
        if (bus.Frame_start) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected_frame at cycle %0d: got frame, expected none", cyc);
            col_n = -1;
          end else begin
            cur = exp_q.pop_front();
            chk("frame_start_cycle", cyc, cur.start);
            col_n = 0;
          end
        end
        if (col_n >= 0) begin
          col_bits[col_n] = bus.Bit_stream;
          col_n++;
          if (col_n == 32) begin
            chk("codeword", col_bits, ref_code(cur.sym));
            col_n = -1;
          end
        end
      end
    end
  end

  // Present inputs for the current cycle, book an accept in the model, advance.
  task automatic drive(input bit v, input int sym, output bit acc);
    int slot;
    bus.Symbol_valid = v;
    bus.Symbol       = symbol_t'(sym);
    acc = v && m_ready(cyc);
    if (acc) begin
      slot = (cyc + 1) / SLOT + 1;
      sched_sym[slot] = sym;
      sched_acc[slot] = cyc;
      exp_q.push_back('{sym, slot * SLOT});
    end
    @(negedge Clock);
  endtask

  task automatic send(input int sym);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) drive(1'b1, sym, acc);
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout at cycle %0d: got no accept, expected one within 100 cycles", cyc);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) drive(1'b0, 0, acc);
  endtask

  task automatic do_reset(input int cycles);
    Reset            = 1'b1;
    bus.Symbol_valid = 1'b0;
    #1;
    chk("rst_bit_stream",   32'(bus.Bit_stream),   32'd0);
    chk("rst_frame_start",  32'(bus.Frame_start),  32'd0);
    chk("rst_busy",         32'(bus.Busy),         32'd0);
    chk("rst_symbol_ready", 32'(bus.Symbol_ready), 32'd1);
    sched_sym.delete();
    sched_acc.delete();
    exp_q.delete();
    col_n = -1;
    repeat (cycles) @(negedge Clock);
    #1 Reset = 1'b0;
  endtask

  initial begin
    bus.Symbol       = '0;
    bus.Symbol_valid = 1'b0;

    // Single symbol 1 at cycle 0: frame in slot 1, busy drops in cycle 65.
    do_reset(3);
    send(1);
    idle(70);

    // Back-to-back 0 then 3: second accept lands in the last slot cycle.
    do_reset(2);
    send(0);
    send(3);
    idle(75);

    // Long idle stretch, then one random symbol to confirm slot alignment.
    idle(100);
    send(int'($urandom_range(0, 15)));
    idle(40);

    // Source holding valid continuously.
    repeat (8) send(int'($urandom_range(0, 15)));

    // Random gaps between symbols.
    repeat (12) begin
      idle(int'($urandom_range(0, 45)));
      send(int'($urandom_range(0, 15)));
    end
    idle(75);

    // Reset at bit 10 of a CODE[2] frame, then every symbol in order.
    do_reset(2);
    send(2);
    while (cyc < 43) idle(1);
    #2;
    do_reset(3);
    for (int k = 0; k < 16; k++) send(k);
    idle(80);

    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_symbol_transmitter.md
# rf_symbol_transmitter

Transmit-side counterpart of the RF correlator receiver. It accepts 4-bit symbols through a valid/ready handshake and maps each one to a 32-bit codeword from a shared 16-entry codebook. It serializes the codeword LSB-first on `Bit_stream` in fixed 33-cycle slots: 32 bit cycles followed by one gap cycle. This matches the receiver's free-running frame counter when both blocks leave reset on the same clock edge. It sits between the symbol source and the RF front end and drives the receiver in loopback.

## Interface
- `GAP_CYCLES`, default 1: idle cycles after the 32 bit cycles. Slot length = 32 + GAP_CYCLES. Must be ≥1; must be 1 for receiver compatibility.
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Symbol`  in  4  symbol to transmit.
- `Symbol_valid`  in  1  `Symbol` is valid this cycle.
- `Symbol_ready`  out  1  block can accept `Symbol` this cycle.
- `Bit_stream`  out  1  serial output, registered.
- `Frame_start`  out  1  high during the first bit cycle of a slot that carries a symbol.
- `Busy`  out  1  a symbol is held or being sent.

## Operation
- Slot counter `sc` counts 0 .. 31+GAP_CYCLES and wraps to 0. It is free-running from reset release, whether or not data is present.
- One-entry hold register (`hold`, `hold_valid`) plus a 32-bit shift register `sh`.
- Accept: a handshake completes on a rising edge with `Symbol_valid && Symbol_ready`. On that edge `hold <= Symbol` and `hold_valid <= 1`.
- `Symbol_ready = !hold_valid || (sc == last)`. In the last cycle, hold transfers to `sh` and a new symbol is accepted on the same edge.
- Edge leaving `sc == last`:
  - if `hold_valid`: `sh <= CODE[hold]`, `active <= 1`, and `hold_valid` is cleared unless a new accept happens on the same edge;
  - else: `sh <= 0`, `active <= 0` (idle slot, all zeros).
- Every other edge: `sh <= {1'b0, sh[31:1]}`.
- `Bit_stream = sh[0]`. During slot cycle n < 32 it carries codeword bit n. During gap cycles it is 0.
- `Frame_start = active && sc == 0`.
- `Busy = hold_valid || (active && sc < 32)`.
- Codebook (Hadamard rows): bit i of `CODE[k]` = 1 iff popcount(i[4:0] & {1'b0,k}) is even.
  - CODE[0] = 32'hFFFF_FFFF
  - CODE[1] = 32'h5555_5555
  - CODE[2] = 32'h3333_3333
  - CODE[3] = 32'h9999_9999
- `Symbol_valid` while not ready: the input is ignored, with no error. The source must hold `Symbol` until accepted.

## Timing
- Reset values: `sc = 0`, `sh = 0`, `hold_valid = 0`, `active = 0`.
- Outputs during reset: `Bit_stream = 0`, `Frame_start = 0`, `Busy = 0`, `Symbol_ready = 1`.
- The first slot after reset is always idle, since no symbol can be loaded before the first wrap.
- Accept-to-first-bit latency = (last − sc_at_accept) + 1 cycles; the range is 1 .. 33 with GAP_CYCLES = 1.
- Sustained throughput: one symbol per 33 cycles. A source holding valid continuously yields back-to-back active slots with no idle slot.
- Reset asserted mid-frame: the frame is aborted immediately. The held symbol is discarded and the outputs return to reset values asynchronously.
- `sc` restarts at 0 on the first edge after release, so slot alignment follows the receiver when both share `Reset`.

## Structure
- Shared package `rf_codebook_pkg` holds:
  - `CODE_BITS = 32`, `SYM_BITS = 4`, `NUM_SYMS = 16`;
  - the `CODE[0:15]` constant array or function;
  - a `symbol_t` typedef.
- The receiver's correlation targets move to the same package.
- Sub-module `rf_code_rom`: combinational symbol → 32-bit codeword lookup, shared with the receiver side. Everything else (counter, hold, shifter) stays in the top module.

## Test plan
- Reset, then Symbol=1 valid at cycle 0 → accepted at cycle 0. Frame_start in cycle 33. Bit_stream over cycles 33..64 = 1,0,1,0,…; cycle 65 = 0. Busy falls in cycle 65.
- Symbol=0 then Symbol=3 offered back-to-back:
  - slot 1 emits 32 ones;
  - the second symbol is accepted in cycle 32 (the `sc == last` concurrent case);
  - slot 2 emits 0x9999_9999 LSB-first (1,0,0,1,…) with no idle slot between.
- Symbol_valid held continuously while hold is full → Symbol_ready low except in gap cycles. Exactly one symbol is accepted per 33 cycles and none are lost or duplicated.
- No valid for 100 cycles → Bit_stream constantly 0, Frame_start never high, `sc` wraps every 33 cycles.
- Reset asserted at bit 10 of a CODE[2] frame → Bit_stream 0 immediately. The next frame starts 33 cycles after release and carries only newly accepted symbols.
- Loopback to the receiver with a shared Clock/Reset, all 16 symbols in sequence → the receiver's `out_str` reports each symbol index one slot later.
